// File: rtl/nco_pkg.sv
// Purpose: shared types, constants and ROM/parameter helpers for the quadrature NCO DAC front end.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
// Contents: quadrant encoding, midscale() code helper, quarter-wave ROM contents generator,
//   parameter-legality check used at elaboration by the top.
package nco_pkg;

  // Quadrant taken from the two MSBs of the truncated phase.
  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  localparam real PI = 3.14159265358979323846;

  // Offset-binary zero point of a dac_w-bit converter.
  function automatic int midscale(input int dac_w);
    return 1 << (dac_w - 1);
  endfunction

  function automatic bit params_ok(input int phase_w, input int lut_aw,
                                   input int amp_w, input int dac_w);
    return (lut_aw >= 1) && (lut_aw + 2 <= phase_w) && (amp_w >= 2) && (amp_w < dac_w);
  endfunction

  // Quarter-wave table entry k: round((2^(amp_w-1)-1) * sin(pi/2 * (k+0.5) / 2^lut_aw)).
  // Half-bin offset keeps the table symmetric so mirroring with ~addr is exact.
  // Sine is evaluated with a Taylor series so only basic real arithmetic is needed.
  function automatic int rom_value(input int k, input int lut_aw, input int amp_w);
    real x;
    real term;
    real s;
    x    = (PI / 2.0) * (real'(k) + 0.5) / real'(1 << lut_aw);
    term = x;
    s    = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    return $rtoi(real'((1 << (amp_w - 1)) - 1) * s + 0.5);
  endfunction

endpackage

// File: rtl/nco_dac_frontend_if.sv
// Purpose: tuning-word load channel (valid/ready) between a controller and the NCO.
// Latency: n/a (wires only).
// Backpressure: ftw_ready low while the NCO still holds an unapplied word.
// Signals: ftw_data (new tuning word), ftw_valid (word offered), ftw_ready (NCO can accept).
interface nco_dac_frontend_if #(
  parameter int PHASE_W = 8
);
  logic [PHASE_W-1:0] ftw_data;
  logic               ftw_valid;
  logic               ftw_ready;

  modport master (output ftw_data, output ftw_valid, input ftw_ready);
  modport slave  (input ftw_data, input ftw_valid, output ftw_ready);
endinterface

// File: rtl/quarter_sine_rom.sv
// Purpose: quarter-wave sine magnitude table with two synchronous read ports (sin and cos paths).
// Latency: 1 cycle from address to data, only on cycles with en_i high.
// Backpressure: none; en_i low holds both outputs.
// Ports: clk, en_i (read enable), addr_a_i/addr_b_i (LUT_AW-bit addresses),
//   data_a_o/data_b_o (AMP_W-1 bit unsigned magnitudes).
module quarter_sine_rom
  import nco_pkg::*;
#(
  parameter int LUT_AW = 6,
  parameter int AMP_W  = 5
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic [LUT_AW-1:0] addr_a_i,
  input  logic [LUT_AW-1:0] addr_b_i,
  output logic [AMP_W-2:0]  data_a_o,
  output logic [AMP_W-2:0]  data_b_o
);

  localparam int DEPTH = 1 << LUT_AW;

  logic [AMP_W-2:0] rom [DEPTH];
  logic [AMP_W-2:0] data_a_q;
  logic [AMP_W-2:0] data_b_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign rom[k] = (AMP_W-1)'(rom_value(k, LUT_AW, AMP_W));
  end

  // No reset: consumers qualify this data with their own pipeline valid.
  always_ff @(posedge clk) begin
    if (en_i) begin
      data_a_q <= rom[addr_a_i];
      data_b_q <= rom[addr_b_i];
    end
  end

  assign data_a_o = data_a_q;
  assign data_b_o = data_b_q;

endmodule

// File: rtl/nco_dac_frontend.sv
// Purpose: quadrature NCO (phase accumulator + quarter-wave ROM) formatting sin/cos to offset-binary DAC codes.
// Latency: 3 clk_en cycles accumulator -> dac_zero_o/dac_one_o; phase_wrap_o 1 cycle after the carry.
// Backpressure: ftw_ready low while a word is pending; clk_en_i low freezes datapath but not the handshake.
// Ports: clk, rst (sync, active high), clk_en_i, ftw_if (tuning-word load, slave), sync_update_i
//   (0 = apply next clk_en, 1 = apply at wrap), mute_i, dac_zero_o (sin), dac_one_o (cos),
//   dac_valid_o (pipeline filled), phase_wrap_o (accumulator carry strobe).
module nco_dac_frontend
  import nco_pkg::*;
#(
  parameter int PHASE_W   = 8,
  parameter int LUT_AW    = 6,
  parameter int AMP_W     = 5,
  parameter int DAC_W     = 6,
  parameter int FTW_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en_i,
  nco_dac_frontend_if.slave ftw_if,
  input  logic              sync_update_i,
  input  logic              mute_i,
  output logic [DAC_W-1:0]  dac_zero_o,
  output logic [DAC_W-1:0]  dac_one_o,
  output logic              dac_valid_o,
  output logic              phase_wrap_o
);

  localparam int              PW      = LUT_AW + 2;
  localparam logic [PW-1:0]   QUARTER = PW'(1 << LUT_AW);
  localparam logic [DAC_W-1:0] MID    = DAC_W'(midscale(DAC_W));

  if (!params_ok(PHASE_W, LUT_AW, AMP_W, DAC_W)) begin : g_bad_params
    $error("nco_dac_frontend: unsupported parameter combination");
  end

  // ---------------- accumulator and tuning-word handshake ----------------
  logic [PHASE_W-1:0] acc_q,      acc_d;
  logic [PHASE_W-1:0] ftw_act_q,  ftw_act_d;
  logic [PHASE_W-1:0] ftw_pend_q, ftw_pend_d;
  logic               pend_q,     pend_d;
  logic               wrap_q,     wrap_d;
  logic [PHASE_W:0]   sum;
  logic               carry;
  logic               accept;

  assign sum              = {1'b0, acc_q} + {1'b0, ftw_act_q};
  assign carry            = sum[PHASE_W];
  assign accept           = ftw_if.ftw_valid && !pend_q;
  assign ftw_if.ftw_ready = !pend_q;

  always_comb begin
    acc_d      = acc_q;
    ftw_act_d  = ftw_act_q;
    ftw_pend_d = ftw_pend_q;
    pend_d     = pend_q;
    wrap_d     = 1'b0;
    if (accept) begin
      ftw_pend_d = ftw_if.ftw_data;
      pend_d     = 1'b1;
    end
    if (clk_en_i) begin
      // The add on the apply cycle still uses the old word, keeping the phase continuous.
      acc_d  = sum[PHASE_W-1:0];
      wrap_d = carry;
      if (pend_q && (!sync_update_i || carry)) begin
        ftw_act_d = ftw_pend_q;
        pend_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      ftw_act_q  <= PHASE_W'(FTW_RESET);
      ftw_pend_q <= '0;
      pend_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      ftw_act_q  <= ftw_act_d;
      ftw_pend_q <= ftw_pend_d;
      pend_q     <= pend_d;
      wrap_q     <= wrap_d;
    end
  end

  // ---------------- lookup helpers ----------------
  function automatic quad_e quad_of(input logic [PW-1:0] p);
    return quad_e'(p[PW-1 -: 2]);
  endfunction

  // Odd quadrants read the table backwards (cos-shaped half of the wave).
  function automatic logic [LUT_AW-1:0] rom_addr(input logic [PW-1:0] p);
    return (quad_of(p) inside {QUAD_1, QUAD_3}) ? ~p[LUT_AW-1:0] : p[LUT_AW-1:0];
  endfunction

  function automatic logic [DAC_W-1:0] to_code(input logic neg, input logic [AMP_W-2:0] mag);
    logic [AMP_W-1:0] smp;
    smp = neg ? -{1'b0, mag} : {1'b0, mag};
    return {{(DAC_W-AMP_W){smp[AMP_W-1]}}, smp} + MID;
  endfunction

  // ---------------- S1 / S2 / S3 pipeline ----------------
  logic [PW-1:0]    p;
  logic [PW-1:0]    s1_sin_q, s1_cos_q;
  logic             s1_vld_q;
  logic             s2_neg_sin_q, s2_neg_cos_q, s2_vld_q;
  logic [AMP_W-2:0] rom_sin, rom_cos;
  logic [DAC_W-1:0] dac_zero_q, dac_zero_d;
  logic [DAC_W-1:0] dac_one_q,  dac_one_d;
  logic             dac_vld_q;

  assign p = acc_q[PHASE_W-1 -: PW];

  quarter_sine_rom #(
    .LUT_AW (LUT_AW),
    .AMP_W  (AMP_W)
  ) u_rom (
    .clk      (clk),
    .en_i     (clk_en_i),
    .addr_a_i (rom_addr(s1_sin_q)),
    .addr_b_i (rom_addr(s1_cos_q)),
    .data_a_o (rom_sin),
    .data_b_o (rom_cos)
  );

  // Midscale until real samples reach S3, so stale pipeline contents never leave after reset.
  always_comb begin
    dac_zero_d = MID;
    dac_one_d  = MID;
    if (!mute_i && s2_vld_q) begin
      dac_zero_d = to_code(s2_neg_sin_q, rom_sin);
      dac_one_d  = to_code(s2_neg_cos_q, rom_cos);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sin_q     <= '0;
      s1_cos_q     <= '0;
      s1_vld_q     <= 1'b0;
      s2_neg_sin_q <= 1'b0;
      s2_neg_cos_q <= 1'b0;
      s2_vld_q     <= 1'b0;
      dac_zero_q   <= MID;
      dac_one_q    <= MID;
      dac_vld_q    <= 1'b0;
    end else if (clk_en_i) begin
      s1_sin_q     <= p;
      s1_cos_q     <= p + QUARTER;
      s1_vld_q     <= 1'b1;
      s2_neg_sin_q <= quad_of(s1_sin_q) inside {QUAD_2, QUAD_3};
      s2_neg_cos_q <= quad_of(s1_cos_q) inside {QUAD_2, QUAD_3};
      s2_vld_q     <= s1_vld_q;
      dac_zero_q   <= dac_zero_d;
      dac_one_q    <= dac_one_d;
      dac_vld_q    <= s2_vld_q;
    end
  end

  assign dac_zero_o   = dac_zero_q;
  assign dac_one_o    = dac_one_q;
  assign dac_valid_o  = dac_vld_q;
  assign phase_wrap_o = wrap_q;

endmodule
